// File: rtl/pfd_cordic_scheduler.sv
// pfd_cordic_scheduler: round-robin sharing of one CORDIC phase pipeline across NCH I/Q phase-detector channels
module pfd_cordic_scheduler #(
  parameter int NCH        = 4,
  parameter int INPUTWIDTH = 14,
  parameter int PHASEWIDTH = 10,
  parameter int TURNWIDTH  = 4,
  parameter int TAGW       = 3,
  parameter int DROPW      = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NCH-1:0]                        ch_en_i,
  input  logic [NCH-1:0]                        s_valid_i,
  input  logic [NCH*INPUTWIDTH-1:0]             s_i_i,
  input  logic [NCH*INPUTWIDTH-1:0]             s_q_i,
  output logic                                  c_valid_o,
  output logic [INPUTWIDTH-1:0]                 c_i_o,
  output logic [INPUTWIDTH-1:0]                 c_q_o,
  output logic [TAGW-1:0]                       c_tag_o,
  input  logic                                  c_ready_i,
  input  logic                                  r_valid_i,
  input  logic [PHASEWIDTH-1:0]                 r_ph_i,
  input  logic [TAGW-1:0]                       r_tag_i,
  output logic [NCH*(TURNWIDTH+PHASEWIDTH)-1:0] integral_o,
  output logic [NCH-1:0]                        upd_o,
  output logic [NCH*DROPW-1:0]                  drop_cnt_o,
  output logic                                  tag_err_o
);
  localparam int W = TURNWIDTH + PHASEWIDTH;
  localparam int NS = 2 ** TAGW;
  localparam logic [TURNWIDTH-1:0] TMIN = {1'b1, {(TURNWIDTH-1){1'b0}}};
  localparam logic [TURNWIDTH-1:0] TMAX = ~TMIN;
  logic [NCH-1:0] pend;
  logic [NS-1:0] pend_pad;
  logic [INPUTWIDTH-1:0] hold_iv [NS];
  logic [INPUTWIDTH-1:0] hold_qv [NS];
  logic [TAGW:0] s;
  logic [TAGW-1:0] gidx, rr_q, rr_d, c_tag_q, c_tag_d;
  logic [INPUTWIDTH-1:0] c_i_q, c_i_d, c_q_q, c_q_d;
  logic found, gnt, c_valid_q, c_valid_d, tag_err_q, tag_err_d, tag_bad;
  logic [1:0] nq;
  assign nq = r_ph_i[PHASEWIDTH-1 -: 2];
  assign tag_bad = {1'b0, r_tag_i} >= (TAGW+1)'(NCH);
  assign gnt = found & (~c_valid_q | c_ready_i);
  // find the first pending channel at or after rr_q; scanning backwards lets the nearest one win
  always_comb begin
    pend_pad = '0;
    pend_pad[NCH-1:0] = pend;
    gidx = '0;
    found = 1'b0;
    s = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      s = {1'b0, rr_q} + (TAGW+1)'(j);
      if (s >= (TAGW+1)'(NCH)) s = s - (TAGW+1)'(NCH);
      if (pend_pad[s[TAGW-1:0]]) begin
        gidx = s[TAGW-1:0];
        found = 1'b1;
      end
    end
  end
  // skid output register holds while stalled, reloads on a grant
  always_comb begin
    c_valid_d = (~c_valid_q | c_ready_i) ? found : c_valid_q;
    c_i_d = gnt ? hold_iv[gidx] : c_i_q;
    c_q_d = gnt ? hold_qv[gidx] : c_q_q;
    c_tag_d = gnt ? gidx : c_tag_q;
    rr_d = gnt ? ((gidx == TAGW'(NCH - 1)) ? '0 : gidx + TAGW'(1)) : rr_q;
    tag_err_d = tag_err_q | (r_valid_i & tag_bad);
  end
  // shared issue state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_valid_q <= 1'b0;
      c_i_q <= '0;
      c_q_q <= '0;
      c_tag_q <= '0;
      rr_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      c_valid_q <= c_valid_d;
      c_i_q <= c_i_d;
      c_q_q <= c_q_d;
      c_tag_q <= c_tag_d;
      rr_q <= rr_d;
      tag_err_q <= tag_err_d;
    end
  end
  assign c_valid_o = c_valid_q;
  assign c_i_o = c_i_q;
  assign c_q_o = c_q_q;
  assign c_tag_o = c_tag_q;
  assign tag_err_o = tag_err_q;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic cap, iss, res, up, dn;
    logic pend_q, pend_d, first_q, first_d, upd_q, upd_d;
    logic [INPUTWIDTH-1:0] si_q, si_d, sq_q, sq_d;
    logic [DROPW-1:0] drop_q, drop_d;
    logic [TURNWIDTH-1:0] turns_q, turns_d;
    logic [PHASEWIDTH-1:0] ph_q, ph_d;
    logic [1:0] lq_q, lq_d;
    assign cap = s_valid_i[g] & ch_en_i[g];
    assign iss = gnt & (gidx == TAGW'(g));
    assign res = r_valid_i & ~tag_bad & (r_tag_i == TAGW'(g));
    assign up = ~first_q & (lq_q == 2'b11) & (nq == 2'b00) & (turns_q != TMAX);
    assign dn = ~first_q & (lq_q == 2'b00) & (nq == 2'b11) & (turns_q != TMIN);
    // capture, drop accounting and quadrant-crossing unwrap for one channel
    always_comb begin
      si_d = cap ? s_i_i[g*INPUTWIDTH +: INPUTWIDTH] : si_q;
      sq_d = cap ? s_q_i[g*INPUTWIDTH +: INPUTWIDTH] : sq_q;
      pend_d = ch_en_i[g] & (cap | (pend_q & ~iss));
      drop_d = (cap & pend_q & ~iss & ~(&drop_q)) ? drop_q + DROPW'(1) : drop_q;
      first_d = ~ch_en_i[g] | (first_q & ~res);
      turns_d = ~res ? turns_q : up ? turns_q + TURNWIDTH'(1) : dn ? turns_q - TURNWIDTH'(1) : turns_q;
      ph_d = res ? r_ph_i : ph_q;
      lq_d = res ? nq : lq_q;
      upd_d = res;
    end
    // per-channel state; reset drops any result arriving in the same cycle
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        si_q <= '0;
        sq_q <= '0;
        pend_q <= 1'b0;
        drop_q <= '0;
        first_q <= 1'b1;
        turns_q <= '0;
        ph_q <= '0;
        lq_q <= '0;
        upd_q <= 1'b0;
      end else begin
        si_q <= si_d;
        sq_q <= sq_d;
        pend_q <= pend_d;
        drop_q <= drop_d;
        first_q <= first_d;
        turns_q <= turns_d;
        ph_q <= ph_d;
        lq_q <= lq_d;
        upd_q <= upd_d;
      end
    end
    assign pend[g] = pend_q;
    assign hold_iv[g] = si_q;
    assign hold_qv[g] = sq_q;
    assign integral_o[g*W +: W] = {turns_q, ph_q};
    assign upd_o[g] = upd_q;
    assign drop_cnt_o[g*DROPW +: DROPW] = drop_q;
  end
  for (genvar g = NCH; g < NS; g++) begin : g_pad
    assign hold_iv[g] = '0;
    assign hold_qv[g] = '0;
  end
endmodule

// File: tb/tb_pfd_cordic_scheduler.sv
// tb_pfd_cordic_scheduler: directed self-checking bench for the shared-CORDIC scheduler
module tb_pfd_cordic_scheduler;
  localparam int NCH = 4, IW = 14, PW = 10, TW = 4, TAGW = 3, DW = 8, W = TW + PW;
  logic clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0] ch_en = '1, s_valid = '0, upd;
  logic [NCH*IW-1:0] s_i = '0, s_q = '0;
  logic c_valid, c_ready = 1'b1, r_valid = 1'b0, tag_err;
  logic [IW-1:0] c_i, c_q;
  logic [TAGW-1:0] c_tag, r_tag = '0;
  logic [PW-1:0] r_ph = '0;
  logic [NCH*W-1:0] integral;
  logic [NCH*DW-1:0] drop;
  int checks = 0, errors = 0;

  pfd_cordic_scheduler #(.NCH(NCH), .INPUTWIDTH(IW), .PHASEWIDTH(PW), .TURNWIDTH(TW), .TAGW(TAGW), .DROPW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .ch_en_i(ch_en), .s_valid_i(s_valid), .s_i_i(s_i), .s_q_i(s_q),
    .c_valid_o(c_valid), .c_i_o(c_i), .c_q_o(c_q), .c_tag_o(c_tag), .c_ready_i(c_ready),
    .r_valid_i(r_valid), .r_ph_i(r_ph), .r_tag_i(r_tag), .integral_o(integral), .upd_o(upd),
    .drop_cnt_o(drop), .tag_err_o(tag_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_res(input logic [TAGW-1:0] t, input logic [PW-1:0] p);
    r_valid = 1'b1;
    r_tag = t;
    r_ph = p;
    tick();
    r_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] integ(input int k);
    return integral[k*W +: W];
  endfunction

  task automatic test_reset;
    do_reset();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_cvalid got %b exp 0", c_valid); end
    checks++; if (integral !== '0) begin errors++; $display("FAIL reset_integral got %h exp 0", integral); end
    checks++; if (drop !== '0) begin errors++; $display("FAIL reset_drop got %h exp 0", drop); end
    checks++; if (upd !== '0) begin errors++; $display("FAIL reset_upd got %b exp 0", upd); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tagerr got %b exp 0", tag_err); end
  endtask

  task automatic test_single;
    s_valid = 4'b0100;
    s_i[2*IW +: IW] = 14'd1000;
    s_q[2*IW +: IW] = 14'd0;
    tick();
    s_valid = '0;
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", c_valid); end
    tick();
    checks++; if ({c_valid, c_tag, c_i, c_q} !== {1'b1, 3'd2, 14'd1000, 14'd0})
      begin errors++; $display("FAIL single_issue got v=%b tag=%0d i=%0d q=%0d exp v=1 tag=2 i=1000 q=0", c_valid, c_tag, c_i, c_q); end
    tick();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got %b exp 0", c_valid); end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int k = 0; k < NCH; k++) s_i[k*IW +: IW] = 14'(100 + k);
    s_valid = 4'b1111;
    tick();
    s_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      tick();
      checks++; if ({c_valid, c_tag, c_i} !== {1'b1, 3'(k), 14'(100 + k)})
        begin errors++; $display("FAIL rr_all got v=%b tag=%0d i=%0d exp v=1 tag=%0d i=%0d", c_valid, c_tag, c_i, k, 100 + k); end
    end
    tick();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", c_valid); end
    s_valid = 4'b1010;
    tick();
    s_valid = '0;
    tick();
    checks++; if ({c_valid, c_tag, c_i} !== {1'b1, 3'd1, 14'd101})
      begin errors++; $display("FAIL rr_odd1 got v=%b tag=%0d i=%0d exp v=1 tag=1 i=101", c_valid, c_tag, c_i); end
    tick();
    checks++; if ({c_valid, c_tag, c_i} !== {1'b1, 3'd3, 14'd103})
      begin errors++; $display("FAIL rr_odd3 got v=%b tag=%0d i=%0d exp v=1 tag=3 i=103", c_valid, c_tag, c_i); end
    tick();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL rr_odd_idle got %b exp 0", c_valid); end
  endtask

  task automatic test_stall;
    do_reset();
    c_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 4'b0001;
      s_i[0 +: IW] = 14'(10 + i);
      tick();
      if (i > 0) begin
        checks++; if ({c_valid, c_tag, c_i} !== {1'b1, 3'd0, 14'd10})
          begin errors++; $display("FAIL stall_hold got v=%b tag=%0d i=%0d exp v=1 tag=0 i=10", c_valid, c_tag, c_i); end
      end
    end
    s_valid = '0;
    checks++; if (drop[0 +: DW] !== 8'd4) begin errors++; $display("FAIL stall_drop got %0d exp 4", drop[0 +: DW]); end
    checks++; if (drop[DW +: 3*DW] !== '0) begin errors++; $display("FAIL stall_drop_other got %h exp 0", drop[DW +: 3*DW]); end
    c_ready = 1'b1;
    tick();
    checks++; if ({c_valid, c_i} !== {1'b1, 14'd15}) begin errors++; $display("FAIL stall_release got v=%b i=%0d exp v=1 i=15", c_valid, c_i); end
    tick();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %b exp 0", c_valid); end
  endtask

  task automatic test_unwrap;
    do_reset();
    send_res(3'd0, 10'h3F0);
    checks++; if (integ(0) !== 14'h03F0) begin errors++; $display("FAIL unwrap_first got %h exp 03f0", integ(0)); end
    checks++; if (upd !== 4'b0001) begin errors++; $display("FAIL unwrap_upd got %b exp 0001", upd); end
    send_res(3'd0, 10'h010);
    checks++; if (integ(0) !== 14'h0410) begin errors++; $display("FAIL unwrap_fwd got %h exp 0410", integ(0)); end
    send_res(3'd0, 10'h010);
    checks++; if (integ(0) !== 14'h0410) begin errors++; $display("FAIL unwrap_same got %h exp 0410", integ(0)); end
    send_res(3'd0, 10'h3F0);
    checks++; if (integ(0) !== 14'h03F0) begin errors++; $display("FAIL unwrap_back got %h exp 03f0", integ(0)); end
    checks++; if (upd !== 4'b0001) begin errors++; $display("FAIL unwrap_upd2 got %b exp 0001", upd); end
    tick();
    checks++; if (upd !== 4'b0000) begin errors++; $display("FAIL unwrap_upd_pulse got %b exp 0000", upd); end
    ch_en = 4'b1110;
    tick();
    checks++; if (integ(0) !== 14'h03F0) begin errors++; $display("FAIL unwrap_disabled_hold got %h exp 03f0", integ(0)); end
    ch_en = 4'b1111;
    send_res(3'd0, 10'h010);
    checks++; if (integ(0) !== 14'h0010) begin errors++; $display("FAIL unwrap_reenable_first got %h exp 0010", integ(0)); end
  endtask

  task automatic test_saturate;
    logic [W-1:0] e;
    send_res(3'd1, 10'h3F0);
    for (int w = 1; w <= 9; w++) begin
      send_res(3'd1, 10'h010);
      e = {4'((w > 7) ? 7 : w), 10'h010};
      checks++; if (integ(1) !== e) begin errors++; $display("FAIL sat_fwd wrap %0d got %h exp %h", w, integ(1), e); end
      send_res(3'd1, 10'h110);
      send_res(3'd1, 10'h210);
      send_res(3'd1, 10'h3F0);
    end
    send_res(3'd1, 10'h010);
    for (int w = 1; w <= 17; w++) begin
      send_res(3'd1, 10'h3F0);
      e = {4'((7 - w < -8) ? -8 : 7 - w), 10'h3F0};
      checks++; if (integ(1) !== e) begin errors++; $display("FAIL sat_back wrap %0d got %h exp %h", w, integ(1), e); end
      send_res(3'd1, 10'h210);
      send_res(3'd1, 10'h110);
      send_res(3'd1, 10'h010);
    end
    send_res(3'd1, 10'h3F0);
    checks++; if (integ(1) !== 14'h23F0) begin errors++; $display("FAIL sat_back_final got %h exp 23f0", integ(1)); end
  endtask

  task automatic test_tag_err;
    send_res(3'd5, 10'h100);
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_set got %b exp 1", tag_err); end
    checks++; if (upd !== 4'b0000) begin errors++; $display("FAIL tagerr_upd got %b exp 0000", upd); end
    checks++; if (integ(1) !== 14'h23F0) begin errors++; $display("FAIL tagerr_ignored got %h exp 23f0", integ(1)); end
    tick();
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_sticky got %b exp 1", tag_err); end
  endtask

  task automatic test_reset_mid;
    s_valid = 4'b1111;
    tick();
    s_valid = '0;
    tick();
    checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", c_valid); end
    rst = 1'b1;
    r_valid = 1'b1;
    r_tag = 3'd0;
    r_ph = 10'h200;
    tick();
    rst = 1'b0;
    r_valid = 1'b0;
    checks++; if ({c_valid, upd, tag_err} !== 6'b0) begin errors++; $display("FAIL mid_ctrl got v=%b upd=%b err=%b exp all 0", c_valid, upd, tag_err); end
    checks++; if (integral !== '0) begin errors++; $display("FAIL mid_integral got %h exp 0", integral); end
    checks++; if (drop !== '0) begin errors++; $display("FAIL mid_drop got %h exp 0", drop); end
    tick();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL mid_pend_cleared got %b exp 0", c_valid); end
    send_res(3'd0, 10'h100);
    checks++; if ({integ(0), upd} !== {14'h0100, 4'b0001}) begin errors++; $display("FAIL mid_after got %h/%b exp 0100/0001", integ(0), upd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_unwrap();
    test_saturate();
    test_tag_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
